// File: rtl/non_blocking.sv
// non_blocking: self-running demonstrator of register update semantics.
//   a/b         - swap pair, exchange values every rising edge (anti-phase
//                 toggle when A_INIT != B_INIT)
//   a_blk/b_blk - pair modelling sequential (blocking-style) assignment:
//                 both collapse to the old b_blk value after one edge
//   pipe_out    - a delayed by DEPTH edges through a zero-reset shift chain
//   swap_cnt    - free-running edge counter since reset, wraps
//   equal       - combinational a == b
// Ports: clk (rising edge), rst_n (async, active low), outputs as above.
module non_blocking #(
    parameter logic A_INIT = 1'b0,
    parameter logic B_INIT = 1'b1,
    parameter int   CNT_W  = 8,
    parameter int   DEPTH  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             a,
    output logic             b,
    output logic             a_blk,
    output logic             b_blk,
    output logic             pipe_out,
    output logic [CNT_W-1:0] swap_cnt,
    output logic             equal
);

    logic [DEPTH-1:0] stage;

    // Swap pair: both right-hand sides read pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= A_INIT;
            b <= B_INIT;
        end else begin
            a <= b;
            b <= a;
        end
    end

    // Blocking model: the second assignment sees the first one's result,
    // so both registers take the old b_blk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_blk <= A_INIT;
            b_blk <= B_INIT;
        end else begin
            a_blk <= b_blk;
            b_blk <= b_blk;
        end
    end

    // Delay chain fed by the pre-edge value of a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= a;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign pipe_out = stage[DEPTH-1];

    // Wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) swap_cnt <= '0;
        else        swap_cnt <= swap_cnt + 1'b1;
    end

    assign equal = (a == b);

endmodule

// File: tb/tb_non_blocking.sv
module tb_non_blocking;

    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic       a0, b0, ab0, bb0, p0, e0;
    logic [7:0] c0;
    // narrow counter instance
    logic       a1, b1, ab1, bb1, p1, e1;
    logic [1:0] c1;
    // equal-init instance
    logic       a2, b2, ab2, bb2, p2, e2;
    logic [7:0] c2;

    non_blocking u_dut (.clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .a_blk(ab0),
        .b_blk(bb0), .pipe_out(p0), .swap_cnt(c0), .equal(e0));
    non_blocking #(.CNT_W(2)) u_w2 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
        .a_blk(ab1), .b_blk(bb1), .pipe_out(p1), .swap_cnt(c1), .equal(e1));
    non_blocking #(.A_INIT(1'b1), .B_INIT(1'b1)) u_eq (.clk(clk), .rst_n(rst_n),
        .a(a2), .b(b2), .a_blk(ab2), .b_blk(bb2), .pipe_out(p2), .swap_cnt(c2),
        .equal(e2));

    int n_chk = 0;
    int n_fail = 0;
    int k = 0;   // rising edges since last reset release

    // Reference model: value after k edges, from the behavioural rules.
    function automatic logic m_a(int n, logic ai, logic bi);
        return (n % 2) ? bi : ai;
    endfunction
    function automatic logic m_b(int n, logic ai, logic bi);
        return (n % 2) ? ai : bi;
    endfunction
    function automatic logic m_ablk(int n, logic ai, logic bi);
        return (n == 0) ? ai : bi;
    endfunction
    function automatic logic m_pipe(int n, logic ai, logic bi);
        return (n < DEPTH) ? 1'b0 : m_a(n - DEPTH, ai, bi);
    endfunction
    function automatic logic [5:0] m_vec(int n, logic ai, logic bi);
        logic ea, eb;
        ea = m_a(n, ai, bi);
        eb = m_b(n, ai, bi);
        return {ea, eb, m_ablk(n, ai, bi), bi, m_pipe(n, ai, bi), ea == eb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if ({a0, b0, ab0, bb0, p0, e0, c0} !== {6'b010100, 8'd0}) begin
                n_fail++;
                $display("FAIL reset_hold: got a,b,ablk,bblk,pipe,eq,cnt=%b%b%b%b%b%b %0d want 010100 0",
                         a0, b0, ab0, bb0, p0, e0, c0);
            end
        end
    endtask

    task automatic test_swap();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if ({a0, b0, e0} !== {m_a(k, 0, 1), m_b(k, 0, 1), 1'b0}) begin
                n_fail++;
                $display("FAIL swap edge %0d: got a,b,eq=%b%b%b want %b%b0",
                         k, a0, b0, e0, m_a(k, 0, 1), m_b(k, 0, 1));
            end
        end
        n_chk++;
        if (c0 !== 8'd5) begin
            n_fail++;
            $display("FAIL swap_cnt: got %0d want 5", c0);
        end
    endtask

    task automatic test_blocking();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if ({ab0, bb0} !== 2'b11) begin
                n_fail++;
                $display("FAIL blocking edge %0d: got a_blk,b_blk=%b%b want 11", k, ab0, bb0);
            end
        end
    endtask

    task automatic test_pipeline();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            n_chk++;
            if (p0 !== m_pipe(k, 0, 1)) begin
                n_fail++;
                $display("FAIL pipeline edge %0d: got %b want %b", k, p0, m_pipe(k, 0, 1));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            step();
            if (i < 5 || i > 250) begin
                n_chk++;
                if (c1 !== 2'(k % 4) || c0 !== 8'(k % 256)) begin
                    n_fail++;
                    $display("FAIL wrap edge %0d: got cnt2=%0d cnt8=%0d want %0d %0d",
                             k, c1, c0, k % 4, k % 256);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (7) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({a0, b0, ab0, bb0, p0, c0, c1} !== {5'b01010, 8'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got a,b,ablk,bblk,pipe=%b%b%b%b%b cnt=%0d cnt2=%0d want 01010 0 0",
                     a0, b0, ab0, bb0, p0, c0, c1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if ({a0, b0, ab0, bb0, p0, e0, c0} !== {m_vec(k, 0, 1), 8'(k)}) begin
                n_fail++;
                $display("FAIL restart edge %0d: got %b%b%b%b%b%b cnt=%0d want %b cnt=%0d",
                         k, a0, b0, ab0, bb0, p0, e0, c0, m_vec(k, 0, 1), k);
            end
        end
    endtask

    task automatic test_equal_init();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            n_chk++;
            if ({a2, b2, e2, c2} !== {3'b111, 8'(k)}) begin
                n_fail++;
                $display("FAIL equal_init edge %0d: got a,b,eq=%b%b%b cnt=%0d want 111 %0d",
                         k, a2, b2, e2, c2, k);
            end
        end
    endtask

    // Random run lengths and random reset points, all instances vs model.
    task automatic test_random();
        for (int it = 0; it < 15; it++) begin
            int n;
            n = $urandom_range(1, 30);
            repeat (n) begin
                step();
                n_chk++;
                if ({a0, b0, ab0, bb0, p0, e0} !== m_vec(k, 0, 1) || c0 !== 8'(k % 256) ||
                    {a1, b1, ab1, bb1, p1, e1} !== m_vec(k, 0, 1) || c1 !== 2'(k % 4) ||
                    {a2, b2, ab2, bb2, p2, e2} !== m_vec(k, 1, 1) || c2 !== 8'(k % 256)) begin
                    n_fail++;
                    $display("FAIL random it %0d edge %0d: dut=%b%b%b%b%b%b/%0d w2=%b%b%b%b%b%b/%0d eq=%b%b%b%b%b%b/%0d want %b %b",
                             it, k, a0, b0, ab0, bb0, p0, e0, c0, a1, b1, ab1, bb1, p1, e1, c1,
                             a2, b2, ab2, bb2, p2, e2, c2, m_vec(k, 0, 1), m_vec(k, 1, 1));
                end
            end
            #($urandom_range(1, 8));
            rst_n = 1'b0;
            #0.5;
            n_chk++;
            if ({a0, b0, ab0, bb0, p0, c0} !== {5'b01010, 8'd0} ||
                {a2, b2, p2, c2} !== {3'b110, 8'd0}) begin
                n_fail++;
                $display("FAIL random_reset it %0d: dut=%b%b%b%b%b/%0d eq=%b%b%b/%0d",
                         it, a0, b0, ab0, bb0, p0, c0, a2, b2, p2, c2);
            end
            @(negedge clk);
            rst_n = 1'b1;
            k = 0;
        end
    endtask

    initial begin
        test_reset();
        test_swap();
        test_blocking();
        test_pipeline();
        test_wrap();
        test_async_reset();
        test_equal_init();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/non_blocking.md
Name: non_blocking

Overview:
- Self-running demonstrator of non-blocking register semantics. Two 1-bit registers exchange values on every rising clock edge, so with unequal initial values they toggle in anti-phase.
- A contrasting pair models blocking-style (sequential) assignment, which collapses both registers to one value after one edge.
- A delay pipeline and a swap counter expose timing for waveform inspection.
- Standalone teaching/regression block with no data inputs; driven only by clock and reset.

Parameters:
A_INIT, 1'b0, reset value of a and a_blk
B_INIT, 1'b1, reset value of b and b_blk
CNT_W, 8, width of swap_cnt (>=1)
DEPTH, 3, stages in the delay pipeline fed by a (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
a  output  1  swap register A (registered)
b  output  1  swap register B (registered)
a_blk  output  1  blocking-model register A (registered)
b_blk  output  1  blocking-model register B (registered)
pipe_out  output  1  a delayed by DEPTH clock edges (registered)
swap_cnt  output  CNT_W  count of rising edges since reset
equal  output  1  combinational, 1 when a == b

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low: asserting it forces all registers to reset values immediately, independent of clk. Release is sampled at the next rising edge.
- Reset values: a=A_INIT, b=B_INIT, a_blk=A_INIT, b_blk=B_INIT, all pipeline stages 0, pipe_out=0, swap_cnt=0.
- Swap, each rising edge with rst_n=1: a_next = b_old and b_next = a_old, updated simultaneously. With default parameters, a reads 1,0,1,... and b reads 0,1,0,... after edges 1,2,3,...; the period is 2 clocks.
- Blocking model, each edge: a_blk_next = b_blk_old, then b_blk_next = a_blk_next, so both equal b_blk_old.
  - After the first edge, a_blk = b_blk = B_INIT, and they stay constant until reset.
- Pipeline: stage[0] captures a_old (a before the edge), and stage[i] captures stage[i-1]. pipe_out = stage[DEPTH-1].
  - After edge k (k>=DEPTH), pipe_out equals the value a held after edge k-DEPTH; edge 0 means the reset value.
  - Before that point pipe_out follows the 0-filled stages.
- swap_cnt increments by 1 on every edge and wraps from 2^CNT_W-1 to 0. No saturation.
- equal = (a == b), combinational from the registers, no latency.
  - With A_INIT != B_INIT, equal is always 0.
  - With A_INIT == B_INIT, a and b never change and equal is always 1.
- Reset asserted mid-operation: all outputs return to reset values within the same time step. Counter and pipeline restart from 0.
- No X propagation: every register has a defined reset value.
- Outputs change only on clk rising edges or rst_n assertion, except equal, which tracks a and b.

Test Plan:
- Reset hold: rst_n=0 for 20 ns with clk running at a 10 ns period -> a=0, b=1, a_blk=0, b_blk=1, pipe_out=0, swap_cnt=0, equal=0 throughout.
- Swap toggling: release rst_n, run 5 edges -> a sequence 1,0,1,0,1; b sequence 0,1,0,1,0; equal=0 at every sample; swap_cnt=5.
- Blocking contrast: same run -> after edge 1, a_blk=1 and b_blk=1, both held 1 for all later edges.
- Pipeline latency, DEPTH=3: after edges 1-3 pipe_out=0,0,0 (fill, then a after reset=0 at edge 3); after edges 4,5,6 -> 1,0,1, i.e. a delayed 3 edges.
- Counter wrap, CNT_W=2: 5 edges -> swap_cnt 1,2,3,0,1.
- Async reset mid-run: assert rst_n=0 between edges after edge 7 -> immediately a=0, b=1, a_blk=0, b_blk=1, swap_cnt=0, pipe_out=0; after release the sequence restarts exactly as in the swap-toggling test.
- Equal-init variant: A_INIT=B_INIT=1 -> a=b=1 constant, equal=1 constant, swap_cnt still increments.
